bcd_field_converter: RTL

- Parametrised, sequential successor to the seconds/minutes digit splitter.
- Converts NUM_FIELDS packed binary fields into packed BCD digits with an iterative double-dabble engine that performs one shift per clock.
- Uses a start/busy/done handshake, flags per-field overflow with saturation, and applies optional leading-zero blanking.
- Sits between the timer counters and the 7-segment scan driver.

---
 rtl/bcd_field_converter_if.sv | 25 ++
 rtl/bcd_field_converter.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/bcd_field_converter_if.sv
// Request/response bundle between the timer counters and the BCD field converter.
// The master drives the request; the slave (the converter) returns status and digits.
interface bcd_field_converter_if #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 6,
  parameter int DIGITS     = 2
);
  logic                           start;
  logic                           blank_en;
  logic [NUM_FIELDS*FIELD_W-1:0]  bin_in;
  logic                           busy;
  logic                           done;
  logic [NUM_FIELDS-1:0]          overflow;
  logic [NUM_FIELDS*DIGITS*4-1:0] bcd_out;

  modport master (
    output start, blank_en, bin_in,
    input  busy, done, overflow, bcd_out
  );

  modport slave (
    input  start, blank_en, bin_in,
    output busy, done, overflow, bcd_out
  );
endinterface

// File: rtl/bcd_field_converter.sv
// Sequential multi-field binary-to-BCD converter: one double-dabble shift per clock,
// per-field saturation on overflow and optional leading-zero blanking.
module bcd_field_converter #(
  parameter int NUM_FIELDS = 2,
  parameter int FIELD_W    = 6,
  parameter int DIGITS     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  bcd_field_converter_if.slave  bus
);

  localparam int SD    = ((FIELD_W + 2) / 3 > DIGITS) ? (FIELD_W + 2) / 3 : DIGITS;
  localparam int SW    = SD * 4;
  localparam int FW    = DIGITS * 4;
  localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int CNT_W = $clog2(FIELD_W + 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STORE, DONE} state_t;

  state_t                        state, state_nxt;
  logic [NUM_FIELDS*FIELD_W-1:0] bin_q;
  logic                          blank_q;
  logic [IDX_W-1:0]              idx;
  logic [CNT_W-1:0]              cnt;
  logic [SW-1:0]                 scratch;
  logic [FIELD_W-1:0]            shreg;
  logic [NUM_FIELDS*FW-1:0]      shadow, shadow_nxt, bcd_q;
  logic [NUM_FIELDS-1:0]         shadow_ovf, ovf_nxt, ovf_q;
  logic [FW:0]                   fin;
  logic                          last_field;

  // One double-dabble iteration: correct digits >= 5, then shift the whole chain left.
  function automatic logic [SW+FIELD_W-1:0] dabble_step(input logic [SW-1:0] s,
                                                        input logic [FIELD_W-1:0] sh);
    logic [SW-1:0] adj;
    for (int k = 0; k < SD; k++)
      adj[k*4 +: 4] = (s[k*4 +: 4] >= 4'd5) ? s[k*4 +: 4] + 4'd3 : s[k*4 +: 4];
    return {adj, sh} << 1;
  endfunction

  // Returns {overflow, digits}: saturates to all nines, else blanks leading zeros.
  function automatic logic [FW:0] finalize(input logic [SW-1:0] s, input logic blank);
    logic          ovf;
    logic          lead;
    logic [FW-1:0] d;
    ovf = 1'b0;
    for (int k = DIGITS; k < SD; k++)
      if (s[k*4 +: 4] != 4'd0) ovf = 1'b1;
    d = s[FW-1:0];
    if (ovf) begin
      for (int k = 0; k < DIGITS; k++) d[k*4 +: 4] = 4'h9;
    end else if (blank) begin
      lead = 1'b1;
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (lead && d[k*4 +: 4] == 4'd0) d[k*4 +: 4] = 4'hF;
        else                             lead = 1'b0;
      end
    end
    return {ovf, d};
  endfunction

  assign fin        = finalize(scratch, blank_q);
  assign last_field = (idx == IDX_W'(NUM_FIELDS - 1));

  always_comb begin
    shadow_nxt                      = shadow;
    ovf_nxt                         = shadow_ovf;
    shadow_nxt[int'(idx)*FW +: FW]  = fin[FW-1:0];
    ovf_nxt[idx]                    = fin[FW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nxt = STORE;
      STORE:   state_nxt = last_field ? DONE : LOAD;
      DONE:    state_nxt = bus.start ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, per-field shift engine, shadow buffer and atomic commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_q      <= '0;
      blank_q    <= 1'b0;
      idx        <= '0;
      cnt        <= '0;
      scratch    <= '0;
      shreg      <= '0;
      shadow     <= '0;
      shadow_ovf <= '0;
      bcd_q      <= '0;
      ovf_q      <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            bin_q   <= bus.bin_in;
            blank_q <= bus.blank_en;
            idx     <= '0;
          end
        end
        LOAD: begin
          scratch <= '0;
          shreg   <= bin_q[int'(idx)*FIELD_W +: FIELD_W];
          cnt     <= CNT_W'(FIELD_W);
        end
        SHIFT: begin
          {scratch, shreg} <= dabble_step(scratch, shreg);
          cnt              <= cnt - CNT_W'(1);
        end
        STORE: begin
          shadow     <= shadow_nxt;
          shadow_ovf <= ovf_nxt;
          if (last_field) begin
            bcd_q <= shadow_nxt;
            ovf_q <= ovf_nxt;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state == LOAD) || (state == SHIFT) || (state == STORE);
  assign bus.done     = (state == DONE);
  assign bus.bcd_out  = bcd_q;
  assign bus.overflow = ovf_q;

endmodule
